xdma_write_arbiter: RTL
=======================

# xdma_write_arbiter

Round-robin arbiter sharing one reqrsp write port among `NumReq` write-only requesters, e.g. several AXI-to-write converters feeding the same XDMA data/cfg sink. Grants are burst-locked: once a requester's first beat is accepted, it owns the port until its `last` beat is accepted, so bursts never interleave at the sink. Arbitration and forwarding are combinational (zero added latency); only the lock state and the round-robin pointer are registered.

## Interface
- `NumReq`, default 2: number of requesters, 2..8.
- `AddrWidth`, default 48: address width.
- `DataWidth`, default 512: data width; strobe width is `DataWidth/8`.
- `IdxWidth`, default `$clog2(NumReq)`: grant index width (derived, do not override).

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, synchronous and active-high.
- `in_q_valid_i`  in  NumReq  per-requester beat valid.
- `in_q_ready_o`  out  NumReq  per-requester beat accepted.
- `in_addr_i`  in  NumReq*AddrWidth  per-requester beat address.
- `in_data_i`  in  NumReq*DataWidth  per-requester write data.
- `in_strb_i`  in  NumReq*DataWidth/8  per-requester byte strobes.
- `in_size_i`  in  NumReq*3  per-requester AXI size.
- `in_last_i`  in  NumReq  beat is the final beat of its burst.
- `out_q_valid_o`  out  1  forwarded beat valid.
- `out_q_ready_i`  in  1  sink accepts beat.
- `out_addr_o`, `out_data_o`, `out_strb_o`, `out_size_o`  out  AddrWidth/DataWidth/DataWidth/8/3  forwarded beat fields.
- `out_write_o`  out  1  constant 1.
- `out_p_ready_o`  out  1  constant 1; write responses are discarded.
- `grant_idx_o`  out  IdxWidth  index of the currently forwarded requester; 0 when `out_q_valid_o` = 0.
- `busy_o`  out  1  any `in_q_valid_i` set, or state is LOCKED.

## Operation
- Registered state: `state_q` ∈ {IDLE, LOCKED}, `owner_q` (IdxWidth), `rr_ptr_q` (IdxWidth).
- IDLE:
  - Winner is the first requester with `in_q_valid_i` set, scanning from `rr_ptr_q` upward and wrapping modulo `NumReq`.
  - Forward the winner's fields; `out_q_valid_o` = 1 if there is any winner.
  - `in_q_ready_o[winner]` = `out_q_ready_i`; all other ready bits are 0.
- Beat accepted in IDLE (winner valid & `out_q_ready_i`):
  - `last` = 0: go to LOCKED, `owner_q` ← winner.
  - `last` = 1: stay IDLE, `rr_ptr_q` ← (winner+1) mod `NumReq`.
- LOCKED:
  - Only `owner_q` is forwarded; `out_q_valid_o` = `in_q_valid_i[owner_q]`.
  - Other requesters see ready = 0 even if the owner is idle (no bubble filling).
  - Owner beat accepted with `last` = 1: go to IDLE, `rr_ptr_q` ← (owner_q+1) mod `NumReq`.
- `rr_ptr_q` changes only on burst completion; an un-accepted grant does not advance it.
- Requesters obey reqrsp rules: valid and fields stable until ready. The arbiter does not re-check this, but IDLE grants may change between cycles while unaccepted if a higher-priority valid appears.
- `NumReq` not a power of two: pointer increment wraps explicitly at `NumReq-1` → 0.

## Timing
- Combinational path from `in_q_valid_i`/`out_q_ready_i` to outputs; zero cycles of latency.
- State updates on the `clk_i` edge following acceptance; the next burst can start in the cycle right after a `last` beat.
- Reset (`rst_i` = 1 on an edge): `state_q` = IDLE, `owner_q` = 0, `rr_ptr_q` = 0. With all inputs low, all outputs are 0 except `out_write_o` and `out_p_ready_o`, which are 1.
- Reset mid-burst: lock is dropped immediately. The next cycle arbitrates from pointer 0. The partial burst is not resumed.
- Simultaneous requests after reset: requester 0 wins first, then 1, and so on.
- Single-beat bursts never enter LOCKED.

## Configuration
- `XDMA_WRITE_ARB_STATS_EN` defined:
  - Adds output `beat_cnt_o` (NumReq*32): per-requester count of accepted beats, saturating at 2^32-1.
  - Adds output `burst_cnt_o` (NumReq*32): per-requester count of accepted `last` beats, saturating at 2^32-1.
  - Both counters clear on `rst_i`.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Reset, then req0 and req1 both valid with single-beat `last` = 1 and `out_q_ready_i` = 1 → grants go 0, 1, 0, 1 on consecutive cycles; `grant_idx_o` alternates.
- req0 sends a 4-beat burst while req1 is continuously valid → 4 beats from req0 with `in_q_ready_o[1]` = 0 throughout, then req1 is granted in cycle 5.
- req0 is LOCKED after beat 1 of 3 and drops valid for 3 cycles → `out_q_valid_o` = 0 for those cycles and req1 is still blocked; burst completes, then req1 is granted.
- `out_q_ready_i` held 0 for 5 cycles with req1 valid → fields stable, `rr_ptr_q` unchanged; ready goes 1 → beat accepted, pointer = 2 mod `NumReq`.
- `rst_i` asserted during beat 2 of a 4-beat burst from req1 → next cycle state is IDLE; req0 and req1 both valid → req0 granted.
- With `XDMA_WRITE_ARB_STATS_EN`: 3 bursts of 2 beats from req0 → `beat_cnt_o[0]` = 6, `burst_cnt_o[0]` = 3, req1 counters = 0.

Source files
------------

// File: rtl/xdma_write_arbiter.sv
// Burst-locked round-robin arbiter merging NumReq write-only reqrsp requesters onto one port.
// Optional per-requester beat/burst counters are enabled by defining XDMA_WRITE_ARB_STATS_EN.
module xdma_write_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 512,
    parameter int unsigned IdxWidth  = $clog2(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             in_q_valid_i,
    output logic [NumReq-1:0]             in_q_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   in_addr_i,
    input  logic [NumReq*DataWidth-1:0]   in_data_i,
    input  logic [NumReq*DataWidth/8-1:0] in_strb_i,
    input  logic [NumReq*3-1:0]           in_size_i,
    input  logic [NumReq-1:0]             in_last_i,
    output logic                          out_q_valid_o,
    input  logic                          out_q_ready_i,
    output logic [AddrWidth-1:0]          out_addr_o,
    output logic [DataWidth-1:0]          out_data_o,
    output logic [DataWidth/8-1:0]        out_strb_o,
    output logic [2:0]                    out_size_o,
    output logic                          out_write_o,
    output logic                          out_p_ready_o,
    output logic [IdxWidth-1:0]           grant_idx_o,
    output logic                          busy_o
`ifdef XDMA_WRITE_ARB_STATS_EN
    ,
    output logic [NumReq*32-1:0]          beat_cnt_o,
    output logic [NumReq*32-1:0]          burst_cnt_o
`endif
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    logic [0:0]          state_q;
    logic [IdxWidth-1:0] owner_q;
    logic [IdxWidth-1:0] rr_ptr_q;

    logic [IdxWidth-1:0] winner;
    logic                winner_found;
    logic [IdxWidth:0]   cand_w;
    logic [IdxWidth-1:0] sel;
    logic                sel_valid;
    logic                sel_last;
    logic                accept;

    // Explicit wrap keeps the pointer legal when NumReq is not a power of two.
    function automatic logic [IdxWidth-1:0] rr_next(input logic [IdxWidth-1:0] idx);
        if (idx == IdxWidth'(NumReq - 1)) begin
            return '0;
        end
        return idx + IdxWidth'(1);
    endfunction

    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand_w       = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand_w = {1'b0, rr_ptr_q} + (IdxWidth + 1)'(i);
            if (cand_w >= (IdxWidth + 1)'(NumReq)) begin
                cand_w = cand_w - (IdxWidth + 1)'(NumReq);
            end
            if (!winner_found && in_q_valid_i[cand_w[IdxWidth-1:0]]) begin
                winner       = cand_w[IdxWidth-1:0];
                winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        if (state_q == StLocked) begin
            sel       = owner_q;
            sel_valid = in_q_valid_i[owner_q];
        end else begin
            sel       = winner;
            sel_valid = winner_found;
        end
        sel_last = in_last_i[sel];
        accept   = sel_valid & out_q_ready_i;

        in_q_ready_o      = '0;
        in_q_ready_o[sel] = accept;
    end

    assign out_q_valid_o = sel_valid;
    assign out_addr_o    = in_addr_i[sel*AddrWidth +: AddrWidth];
    assign out_data_o    = in_data_i[sel*DataWidth +: DataWidth];
    assign out_strb_o    = in_strb_i[sel*StrbWidth +: StrbWidth];
    assign out_size_o    = in_size_i[sel*3 +: 3];
    assign out_write_o   = 1'b1;
    assign out_p_ready_o = 1'b1;
    assign grant_idx_o   = sel_valid ? sel : '0;
    assign busy_o        = (|in_q_valid_i) | (state_q == StLocked);

    // Pointer moves only when a burst completes, so a stalled grant keeps its priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else if (accept) begin
            if (state_q == StIdle) begin
                if (sel_last) begin
                    rr_ptr_q <= rr_next(winner);
                end else begin
                    state_q <= StLocked;
                    owner_q <= winner;
                end
            end else if (sel_last) begin
                state_q  <= StIdle;
                rr_ptr_q <= rr_next(owner_q);
            end
        end
    end

`ifdef XDMA_WRITE_ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    for (genvar g = 0; g < NumReq; g++) begin : g_stats
        logic [31:0] beat_q;
        logic [31:0] burst_q;
        logic        fire;

        assign fire = in_q_valid_i[g] & in_q_ready_o[g];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                beat_q  <= '0;
                burst_q <= '0;
            end else if (fire) begin
                beat_q <= sat_inc(beat_q);
                if (in_last_i[g]) begin
                    burst_q <= sat_inc(burst_q);
                end
            end
        end

        assign beat_cnt_o[g*32 +: 32]  = beat_q;
        assign burst_cnt_o[g*32 +: 32] = burst_q;
    end
`endif

endmodule
